uart_mux: RTL

Packet-building UART transmitter; the transmit-side counterpart of the team's UART packet demux.
- Accepts a burst of 1..MAX_BYTES bytes aimed at one 8-bit address.
- Buffers the burst and computes its checksum.
- Serializes it on UART_TX as: checksum | address | count | (count+1) data bytes.
- Sits between on-chip logic and the host link, so the same packet format flows FPGA->host.

---
 rtl/uart_mux.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_mux.sv
// rtl/uart_mux.sv - packet-building UART transmitter: checksum | addr | count | data
module uart_mux #(
   parameter int CLKS_PER_BIT = 16,
   parameter int MAX_BYTES    = 256
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [7:0] in_addr,
   input  logic       in_last,
   output logic       UART_TX,
   output logic       busy,
   output logic       tx_done,
   output logic       truncated
);
   localparam int AW = $clog2(MAX_BYTES);
   localparam int NW = AW + 1;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [AW:0]   N_MAX    = NW'(MAX_BYTES);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

   // Each SEND_* state names the byte that will be handed to the serializer next
   typedef enum logic [2:0] {COLLECT, SEND_CK, SEND_ADDR, SEND_CNT, SEND_DATA} state_t;
   state_t state, state_nxt;

   logic [7:0]    mem [MAX_BYTES];
   logic [AW:0]   n_q;        // bytes collected; extra bit keeps a full buffer distinct from empty
   logic [AW:0]   rd_q;       // data bytes already handed to the serializer
   logic [7:0]    sum_q, addr_q, cnt_q, ck_q;

   logic          accept, first, close;
   logic [AW:0]   n_inc;
   logic [7:0]    sum_new, cnt_new;

   logic          ser_busy;
   logic [CW-1:0] clk_cnt;
   logic [3:0]    bit_cnt;    // 0 = start, 1..8 = data, 9 = stop
   logic [8:0]    shreg;
   logic          bit_end, frame_end, ser_free;

   logic          load, done;
   logic [7:0]    load_byte;

   assign in_ready  = (state == COLLECT) && !RESET;
   assign accept    = in_valid && in_ready;
   assign first     = (n_q == '0);
   assign n_inc     = n_q + 1'b1;
   assign sum_new   = first ? (in_addr + in_data) : (sum_q + in_data);
   assign cnt_new   = 8'(n_q);
   assign close     = accept && (in_last || (n_inc == N_MAX));

   assign bit_end   = (clk_cnt == BIT_LAST);
   assign frame_end = ser_busy && bit_end && (bit_cnt == 4'd9);
   // A new frame may start on the very cycle the previous stop bit ends
   assign ser_free  = !ser_busy || frame_end;

   // State register
   always_ff @(posedge clk) begin
      if (RESET) state <= COLLECT;
      else       state <= state_nxt;
   end

   // Next-state logic and serializer load requests
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_byte = 8'h00;
      done      = 1'b0;
      case (state)
         COLLECT:   if (close) state_nxt = SEND_CK;
         SEND_CK:   if (ser_free) begin
                       load = 1'b1; load_byte = ck_q;   state_nxt = SEND_ADDR;
                    end
         SEND_ADDR: if (ser_free) begin
                       load = 1'b1; load_byte = addr_q; state_nxt = SEND_CNT;
                    end
         SEND_CNT:  if (ser_free) begin
                       load = 1'b1; load_byte = cnt_q;  state_nxt = SEND_DATA;
                    end
         SEND_DATA: if (ser_free) begin
                       if (rd_q != n_q) begin
                          load      = 1'b1;
                          load_byte = mem[rd_q[AW-1:0]];
                       end else begin
                          done      = 1'b1;
                          state_nxt = COLLECT;
                       end
                    end
         default:   state_nxt = COLLECT;
      endcase
   end

   // Payload buffer write; contents need no reset
   always_ff @(posedge clk) begin
      if (accept) mem[n_q[AW-1:0]] <= in_data;
   end

   // Packet bookkeeping: byte count, running sum, header bytes, status pulses
   always_ff @(posedge clk) begin
      if (RESET) begin
         n_q       <= '0;
         rd_q      <= '0;
         sum_q     <= 8'h00;
         addr_q    <= 8'h00;
         cnt_q     <= 8'h00;
         ck_q      <= 8'h00;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
         truncated <= 1'b0;
      end else begin
         tx_done   <= done;
         truncated <= close && !in_last;
         if (accept) begin
            n_q   <= n_inc;
            sum_q <= sum_new;
            if (first) begin
               addr_q <= in_addr;
               busy   <= 1'b1;
            end
         end
         if (close) begin
            cnt_q <= cnt_new;
            ck_q  <= 8'h00 - (sum_new + cnt_new);
         end
         if ((state == SEND_DATA) && load) rd_q <= rd_q + 1'b1;
         if (done) begin
            n_q   <= '0;
            rd_q  <= '0;
            sum_q <= 8'h00;
            busy  <= 1'b0;
         end
      end
   end

   // 8N1 serializer, LSB first, with a registered line output
   always_ff @(posedge clk) begin
      if (RESET) begin
         ser_busy <= 1'b0;
         clk_cnt  <= '0;
         bit_cnt  <= 4'd0;
         shreg    <= 9'h1FF;
         UART_TX  <= 1'b1;
      end else if (load) begin
         ser_busy <= 1'b1;
         clk_cnt  <= '0;
         bit_cnt  <= 4'd0;
         shreg    <= {1'b1, load_byte};
         UART_TX  <= 1'b0;
      end else if (ser_busy) begin
         if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               ser_busy <= 1'b0;
               UART_TX  <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               UART_TX <= shreg[0];
               shreg   <= {1'b1, shreg[8:1]};
            end
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
      end
   end
endmodule
